irq_arbiter: RTL and testbench

- Interrupt controller for the bamse PicoBlaze (pacoblaze3) SoC.
- Collects up to 8 asynchronous interrupt sources: push buttons, timer0 and UART RX done.
- Arbitrates them by fixed priority onto the single `interrupt` input of the CPU and completes the interrupt/interrupt_ack handshake.
- Software sees a small port-mapped register file: pending, mask, vector and EOI.
- Sits beside the ports block on the pblaze port bus.

---
 rtl/irq_arbiter_pkg.sv | 26 ++
 rtl/irq_edge_sync.sv | 30 +++
 rtl/irq_arbiter.sv | 128 ++++++++++++
 tb/tb_irq_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_arbiter_pkg.sv
// irq_arbiter_pkg: shared register offsets, FSM states and helpers for irq_arbiter.
package irq_arbiter_pkg;

    // Register offsets relative to BASE_ADDR
    localparam logic [1:0] IRQ_PEND = 2'd0;
    localparam logic [1:0] IRQ_MASK = 2'd1;
    localparam logic [1:0] IRQ_VEC  = 2'd2;
    localparam logic [1:0] IRQ_EOI  = 2'd3;

    // Bit of the VECTOR register that mirrors in_service
    localparam int VEC_VALID_BIT = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    // Index of the lowest set bit; source 0 has the highest priority
    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        lowest_idx = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (v[i]) lowest_idx = 3'(i);
    endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// irq_edge_sync: synchronizes one asynchronous source and emits a one-cycle rising-edge pulse.
//   clk, rst  : clock, asynchronous active-high reset
//   i_async   : raw asynchronous input
//   o_rise    : one-cycle pulse on a synchronized 0->1 transition
module irq_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    // Combinational so the pending bit sets on the edge after the last sync stage
    assign o_rise = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/irq_arbiter.sv
// irq_arbiter: fixed-priority interrupt controller for the pacoblaze3 interrupt/ack handshake.
//   clk, rst                  : clock, asynchronous active-high reset
//   irq_src[NSRC]             : raw rising-edge interrupt sources (source 0 highest priority)
//   port_id, write_strobe,
//   read_strobe, out_port     : pblaze port bus (PENDING/MASK/VECTOR/EOI at BASE_ADDR+0..3)
//   in_port, in_sel           : combinational read data and address-hit flag
//   interrupt, interrupt_ack  : CPU request / one-cycle acknowledge
//   in_service                : an ISR is running until EOI is written
module irq_arbiter
    import irq_arbiter_pkg::*;
#(
    parameter int         NSRC        = 4,
    parameter logic [7:0] BASE_ADDR   = 8'h40,
    parameter int         SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_src,
    input  logic [7:0]      port_id,
    input  logic            write_strobe,
    input  logic            read_strobe,
    input  logic [7:0]      out_port,
    output logic [7:0]      in_port,
    output logic            in_sel,
    output logic            interrupt,
    input  logic            interrupt_ack,
    output logic            in_service
);

    logic [NSRC-1:0] w_rise, w_req, w_w1c, w_ack_clr;
    logic [NSRC-1:0] r_pend, r_mask;
    logic [7:0]      w_off, w_pend8, w_mask8, w_req8, w_vec8, w_stat8;
    logic            w_wr, w_ack, w_eoi;
    logic [2:0]      r_sel, r_vec;
    logic            r_irq, r_insvc;
    irq_state_t      r_state;
    logic [8:0]      w_unused;

    genvar i;
    generate
        for (i = 0; i < NSRC; i++) begin : g_src
            irq_edge_sync #(.STAGES(SYNC_STAGES)) u_sync (
                .clk    (clk),
                .rst    (rst),
                .i_async(irq_src[i]),
                .o_rise (w_rise[i])
            );
        end
    endgenerate

    // Reads have no side effects, and only the low NSRC data bits are stored
    assign w_unused  = {read_strobe, out_port};

    assign w_off     = port_id - BASE_ADDR;
    assign in_sel    = w_off < 8'd4;
    assign w_wr      = write_strobe && in_sel;
    assign w_eoi     = w_wr && w_off[1:0] == IRQ_EOI;
    assign w_ack     = r_state == REQ && interrupt_ack;
    assign w_req     = r_pend & r_mask;
    assign w_w1c     = (w_wr && w_off[1:0] == IRQ_PEND) ? out_port[NSRC-1:0] : '0;
    assign w_ack_clr = w_ack ? NSRC'(1) << r_sel : '0;

    always_comb begin
        w_pend8                = '0;
        w_mask8                = '0;
        w_req8                 = '0;
        w_vec8                 = '0;
        w_pend8[NSRC-1:0]      = r_pend;
        w_mask8[NSRC-1:0]      = r_mask;
        w_req8[NSRC-1:0]       = w_req;
        w_vec8[2:0]            = r_vec;
        w_vec8[VEC_VALID_BIT]  = r_insvc;
    end

    assign w_stat8 = {6'b0, r_irq, r_insvc};

    assign in_port = !in_sel                  ? 8'h00   :
                     w_off[1:0] == IRQ_PEND   ? w_pend8 :
                     w_off[1:0] == IRQ_MASK   ? w_mask8 :
                     w_off[1:0] == IRQ_VEC    ? w_vec8  : w_stat8;

    // A new edge always wins over both software W1C and the ack clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
            r_mask <= '0;
        end else begin
            r_pend <= (r_pend & ~w_w1c & ~w_ack_clr) | w_rise;
            if (w_wr && w_off[1:0] == IRQ_MASK)
                r_mask <= out_port[NSRC-1:0];
        end
    end

    // sel_id is latched on leaving IDLE and frozen until the ack, whatever
    // software does to pending or mask in between
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_vec   <= '0;
            r_irq   <= 1'b0;
            r_insvc <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (|w_req) begin
                    r_sel   <= lowest_idx(w_req8);
                    r_irq   <= 1'b1;
                    r_state <= REQ;
                end
                REQ: if (interrupt_ack) begin
                    r_irq   <= 1'b0;
                    r_vec   <= r_sel;
                    r_insvc <= 1'b1;
                    r_state <= SERVICE;
                end
                SERVICE: if (w_eoi) begin
                    r_insvc <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign interrupt  = r_irq;
    assign in_service = r_insvc;

endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: table, directed and randomized checks of irq_arbiter against a behavioural model.
module tb_irq_arbiter;

    localparam int         NSRC = 4;
    localparam int         SYNC = 2;
    localparam logic [7:0] BASE = 8'h40;
    localparam logic [7:0] LOW  = 8'h0F;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NSRC-1:0] irq_src = '0;
    logic [7:0]      port_id = 8'h00;
    logic            write_strobe = 1'b0;
    logic            read_strobe = 1'b0;
    logic [7:0]      out_port = 8'h00;
    logic [7:0]      in_port;
    logic            in_sel;
    logic            interrupt;
    logic            interrupt_ack = 1'b0;
    logic            in_service;

    int total = 0;
    int bad   = 0;

    irq_arbiter #(.NSRC(NSRC), .BASE_ADDR(BASE), .SYNC_STAGES(SYNC)) dut (
        .clk          (clk),
        .rst          (rst),
        .irq_src      (irq_src),
        .port_id      (port_id),
        .write_strobe (write_strobe),
        .read_strobe  (read_strobe),
        .out_port     (out_port),
        .in_port      (in_port),
        .in_sel       (in_sel),
        .interrupt    (interrupt),
        .interrupt_ack(interrupt_ack),
        .in_service   (in_service)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Behavioural model: samples of irq_src, newest first
    logic [7:0] hist[$];
    logic [7:0] m_pend, m_mask;
    logic [2:0] m_sel, m_vec;
    logic       m_irq, m_insvc;
    int         m_state;   // 0 idle, 1 requesting, 2 servicing

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_mask = 0; m_sel = 0; m_vec = 0;
        m_irq = 0; m_insvc = 0; m_state = 0;
        hist.delete();
        for (int n = 0; n < SYNC + 2; n++) hist.push_back(8'h00);
    endtask

    function automatic logic [7:0] exp_rd(input logic [7:0] pid);
        int k = int'(pid) - int'(BASE);
        if (k < 0 || k > 3) return 8'h00;
        if (k == 0) return m_pend;
        if (k == 1) return m_mask;
        if (k == 2) return {m_insvc, 4'b0, m_vec};
        return {6'b0, m_irq, m_insvc};
    endfunction

    task automatic model_step();
        logic [7:0] edges, req, lsb, nxt_pend;
        int  k;
        bit  wr;
        hist.push_front(8'(irq_src) & LOW);
        // A source is seen rising SYNC edges after it was first sampled high
        edges = hist[SYNC] & ~hist[SYNC+1];
        void'(hist.pop_back());
        k  = int'(port_id) - int'(BASE);
        wr = write_strobe && k >= 0 && k < 4;
        nxt_pend = m_pend;
        if (wr && k == 0) nxt_pend = nxt_pend & ~out_port;
        if (m_state == 1 && interrupt_ack) nxt_pend = nxt_pend & ~(8'h01 << m_sel);
        nxt_pend = (nxt_pend | edges) & LOW;
        req = m_pend & m_mask;
        if (m_state == 0 && req != 0) begin
            lsb = req & (~req + 8'd1);
            m_sel = 3'($clog2(lsb));
            m_irq = 1; m_state = 1;
        end else if (m_state == 1 && interrupt_ack) begin
            m_vec = m_sel; m_irq = 0; m_insvc = 1; m_state = 2;
        end else if (m_state == 2 && wr && k == 3) begin
            m_insvc = 0; m_state = 0;
        end
        if (wr && k == 1) m_mask = out_port & LOW;
        m_pend = nxt_pend;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("interrupt", int'(interrupt), int'(m_irq));
        chk("in_service", int'(in_service), int'(m_insvc));
        chk("in_sel", int'(in_sel), int'(exp_rd_sel(port_id)));
        chk("in_port", int'(in_port), int'(exp_rd(port_id)));
    endtask

    function automatic bit exp_rd_sel(input logic [7:0] pid);
        return pid >= BASE && pid <= BASE + 8'd3;
    endfunction

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        port_id = a; out_port = d; write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string nm);
        port_id = a;
        #1;
        chk(nm, int'(in_port), int'(exp));
    endtask

    task automatic ack();
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
    endtask

    task automatic wait_irq(input string nm);
        for (int n = 0; n < 20 && !interrupt; n++) tick();
        chk(nm, int'(interrupt), 1);
    endtask

    task automatic do_reset();
        irq_src = '0; write_strobe = 0; interrupt_ack = 0; port_id = 0; out_port = 0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
    endtask

    typedef struct {
        logic [7:0] pid;
        logic       sel;
        logic [7:0] data;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{8'h3F, 1'b0, 8'h00};
        tbl[1] = '{8'h40, 1'b1, 8'h00};
        tbl[2] = '{8'h41, 1'b1, 8'h0B};
        tbl[3] = '{8'h42, 1'b1, 8'h00};
        tbl[4] = '{8'h43, 1'b1, 8'h00};
        tbl[5] = '{8'h44, 1'b0, 8'h00};
        tbl[6] = '{8'h00, 1'b0, 8'h00};
        tbl[7] = '{8'hFF, 1'b0, 8'h00};
        tbl[8] = '{8'hC1, 1'b0, 8'h00};
        tbl[9] = '{8'h01, 1'b0, 8'h00};

        // Reset state
        do_reset();
        chk("rst_interrupt", int'(interrupt), 0);
        chk("rst_in_service", int'(in_service), 0);
        for (int k = 0; k < 4; k++) rd(BASE + 8'(k), 8'h00, "rst_reg");

        // Address decode table; out-of-range writes must not land
        wr(8'h41, 8'hFB);
        wr(8'h45, 8'h0F);
        wr(8'h3D, 8'h0F);
        for (int n = 0; n < 10; n++) begin
            port_id = tbl[n].pid;
            #1;
            chk("tbl_in_sel", int'(in_sel), int'(tbl[n].sel));
            chk("tbl_in_port", int'(in_port), int'(tbl[n].data));
        end

        // 1: single source, latency and ack
        wr(8'h41, 8'h0F);
        irq_src = 4'b0100;
        repeat (3) tick();
        rd(8'h40, 8'h04, "t1_pend_latency");
        chk("t1_irq_before", int'(interrupt), 0);
        tick();
        chk("t1_irq", int'(interrupt), 1);
        tick();
        irq_src = '0;
        ack();
        chk("t1_irq_after_ack", int'(interrupt), 0);
        rd(8'h42, 8'h82, "t1_vector");
        rd(8'h40, 8'h00, "t1_pend_cleared");
        wr(8'h43, 8'h00);
        repeat (4) tick();

        // 2: simultaneous edges served in index order
        irq_src = 4'b1010;
        tick();
        irq_src = '0;
        wait_irq("t2_wait1");
        ack();
        rd(8'h42, 8'h81, "t2_vector1");
        repeat (2) tick();
        chk("t2_irq_low_in_service", int'(interrupt), 0);
        rd(8'h40, 8'h08, "t2_pend_left");
        wr(8'h43, 8'h00);
        wait_irq("t2_wait2");
        ack();
        rd(8'h42, 8'h83, "t2_vector2");
        wr(8'h43, 8'h00);
        repeat (2) tick();

        // 3: masked source, late unmask, W1C during REQ
        wr(8'h41, 8'h00);
        irq_src = 4'b0001;
        tick();
        irq_src = '0;
        repeat (5) tick();
        rd(8'h40, 8'h01, "t3_pend_masked");
        chk("t3_no_irq", int'(interrupt), 0);
        wr(8'h41, 8'h01);
        tick();
        chk("t3_irq_unmask", int'(interrupt), 1);
        rd(8'h43, 8'h02, "t3_status_req");
        wr(8'h40, 8'h01);
        chk("t3_irq_after_w1c", int'(interrupt), 1);
        rd(8'h40, 8'h00, "t3_pend_w1c");
        ack();
        rd(8'h42, 8'h80, "t3_vector");
        rd(8'h43, 8'h01, "t3_status_svc");
        wr(8'h43, 8'h00);
        repeat (2) tick();

        // 4a: edge coincides with W1C of the same bit
        wr(8'h41, 8'h00);
        irq_src = 4'b0010;
        repeat (2) tick();
        wr(8'h40, 8'h02);
        rd(8'h40, 8'h02, "t4_edge_beats_w1c");
        irq_src = '0;
        repeat (3) tick();
        // 4b: edge on sel_id coincides with ack
        wr(8'h41, 8'h02);
        tick();
        chk("t4_irq", int'(interrupt), 1);
        irq_src = 4'b0010;
        repeat (2) tick();
        ack();
        rd(8'h42, 8'h81, "t4_vector");
        rd(8'h40, 8'h02, "t4_edge_beats_ack");
        chk("t4_irq_after_ack", int'(interrupt), 0);
        wr(8'h43, 8'h00);
        wait_irq("t4_reserve");
        ack();
        rd(8'h42, 8'h81, "t4_vector2");
        rd(8'h40, 8'h00, "t4_pend_clear");
        wr(8'h43, 8'h00);
        irq_src = '0;
        repeat (3) tick();

        // 5: spurious ack and EOI in IDLE, reset during REQ
        ack();
        chk("t5_spurious_ack", int'(in_service), 0);
        wr(8'h43, 8'hFF);
        rd(8'h43, 8'h00, "t5_status_idle");
        rd(8'h42, 8'h01, "t5_vector_idle");
        wr(8'h41, 8'h01);
        irq_src = 4'b0001;
        wait_irq("t5_wait");
        irq_src = '0;
        rst = 1'b1;
        #1;
        chk("t5_rst_async_irq", int'(interrupt), 0);
        do_reset();
        for (int k = 0; k < 4; k++) rd(BASE + 8'(k), 8'h00, "t5_reg_after_rst");

        // Randomized traffic against the model
        for (int c = 0; c < 500; c++) begin
            for (int b = 0; b < NSRC; b++)
                if ($urandom_range(5) == 0) irq_src[b] = ~irq_src[b];
            write_strobe  = ($urandom_range(3) == 0);
            port_id       = 8'(int'(BASE) - 1 + int'($urandom_range(5)));
            out_port      = 8'($urandom);
            interrupt_ack = ($urandom_range(2) == 0);
            tick();
        end
        write_strobe = 0; interrupt_ack = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
